ahb_gpio_slave: RTL and testbench

//  AHB slave with a memory-mapped GPIO register file. Drives one slave-side

---
 rtl/ahb_pkg.sv | 18 +
 rtl/gpio_sync_edge.sv | 16 +
 rtl/ahb_gpio_slave.sv | 97 +++++++++
 tb/tb_ahb_gpio_slave.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB encodings, GPIO register offsets and slave FSM states
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ = 2'b11;
  localparam logic [1:0] HRESP_OKAY = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic [2:0] REG_DATA_OUT = 3'd0;
  localparam logic [2:0] REG_DIR = 3'd1;
  localparam logic [2:0] REG_DATA_IN = 3'd2;
  localparam logic [2:0] REG_INT_EN = 3'd3;
  localparam logic [2:0] REG_INT_STAT = 3'd4;
  typedef enum logic [1:0] {ST_IDLE, ST_RWAIT, ST_ERR1, ST_ERR2} state_t;
endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: two-flop input synchroniser with rising-edge pulse
module gpio_sync_edge #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] sync_q,
  output logic [W-1:0] rise_pulse
);
  logic [W-1:0] s1, prev;
  always_ff @(posedge clk)
    if (rst) {s1, sync_q, prev} <= '0;
    else {s1, sync_q, prev} <= {d, s1, sync_q};
  assign rise_pulse = sync_q & ~prev;
endmodule

// File: rtl/ahb_gpio_slave.sv
// ahb_gpio_slave: AHB slave with GPIO register file, read wait states and edge interrupts
module ahb_gpio_slave
  import ahb_pkg::*;
#(
  parameter int GPIO_W = 32,
  parameter int READ_WAIT = 1
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY_IN,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP,
  output logic [31:0]       HRDATA,
  output logic [3:0]        HSPLITx,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq
);
  localparam logic [1:0] LAST = 2'(READ_WAIT == 0 ? 0 : READ_WAIT - 1);
  state_t state, nxt;
  logic [1:0] cnt;
  logic d_act, d_write;
  logic [2:0] d_off;
  logic [GPIO_W-1:0] int_en, int_stat, sync_q, rise, w1c;
  logic acc, err, we, rd_done;
  logic [31:0] rmux;
  logic unused_ok;
  gpio_sync_edge #(.W(GPIO_W)) u_sync (
    .clk(HCLK), .rst(HRESET), .d(gpio_in), .sync_q(sync_q), .rise_pulse(rise)
  );
  assign acc = HSEL & HREADY_IN & HTRANS[1];
  assign err = HADDR[4:2] > REG_INT_STAT || HADDR[1:0] != 2'b00 || HSIZE != HSIZE_WORD ||
               (HWRITE && HADDR[4:2] == REG_DATA_IN);
  assign we = d_act & d_write;
  assign rd_done = d_act & ~d_write & (state == ST_IDLE);
  assign w1c = we && d_off == REG_INT_STAT ? HWDATA[GPIO_W-1:0] : '0;
  assign HSPLITx = '0;
  assign unused_ok = ^{HADDR[31:5], HTRANS[0], HWDATA};
  always_ff @(posedge HCLK)
    if (HRESET) begin
      state <= ST_IDLE;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= state == ST_RWAIT ? cnt + 2'd1 : '0;
    end
  always_comb begin
    nxt = state;
    HREADYOUT = 1'b1;
    HRESP = HRESP_OKAY;
    case (state)
      ST_IDLE, ST_ERR2: nxt = acc && err ? ST_ERR1 :
                              acc && !HWRITE && READ_WAIT != 0 ? ST_RWAIT : ST_IDLE;
      ST_RWAIT: nxt = cnt == LAST ? ST_IDLE : ST_RWAIT;
      ST_ERR1: nxt = ST_ERR2;
      default: nxt = ST_IDLE;
    endcase
    HREADYOUT = state != ST_RWAIT && state != ST_ERR1;
    HRESP = state == ST_ERR1 || state == ST_ERR2 ? HRESP_ERROR : HRESP_OKAY;
  end
  // Erroneous transfers never open a data phase, so they cannot touch a register.
  always_ff @(posedge HCLK)
    if (HRESET) begin
      d_act <= 1'b0;
      d_write <= 1'b0;
      d_off <= '0;
      gpio_out <= '0;
      gpio_oe <= '0;
      int_en <= '0;
      int_stat <= '0;
      irq <= 1'b0;
    end else begin
      if (HREADY_IN) begin
        d_act <= acc & ~err;
        d_write <= HWRITE;
        d_off <= HADDR[4:2];
      end
      if (we && d_off == REG_DATA_OUT) gpio_out <= HWDATA[GPIO_W-1:0];
      if (we && d_off == REG_DIR) gpio_oe <= HWDATA[GPIO_W-1:0];
      if (we && d_off == REG_INT_EN) int_en <= HWDATA[GPIO_W-1:0];
      int_stat <= (int_stat & ~w1c) | rise;
      irq <= |(int_stat & int_en);
    end
  assign rmux = d_off == REG_DATA_OUT ? 32'(gpio_out) :
                d_off == REG_DIR ? 32'(gpio_oe) :
                d_off == REG_DATA_IN ? 32'(sync_q) :
                d_off == REG_INT_EN ? 32'(int_en) :
                d_off == REG_INT_STAT ? 32'(int_stat) : '0;
  assign HRDATA = rd_done ? rmux : '0;
endmodule

// File: tb/tb_ahb_gpio_slave.sv
// tb_ahb_gpio_slave: random AHB traffic against a register-level reference model
module tb_ahb_gpio_slave;
  localparam int GW = 16;
  localparam int RW = 2;
  localparam logic [31:0] MASK = (32'd1 << GW) - 32'd1;
  logic HCLK = 1'b0, HRESET = 1'b1, HSEL = 1'b0, HWRITE = 1'b0;
  logic [31:0] HADDR = '0, HWDATA = '0;
  logic [1:0] HTRANS = 2'b00;
  logic [2:0] HSIZE = 3'b010;
  logic HREADY_IN, HREADYOUT, irq;
  logic [1:0] HRESP;
  logic [31:0] HRDATA;
  logic [3:0] HSPLITx;
  logic [GW-1:0] gpio_in = '0, gpio_out, gpio_oe;
  int n_chk = 0, n_fail = 0;
  logic [31:0] m_dout, m_dir, m_en, m_stat, s0, s1, s2;
  logic m_irq, pend_we;
  logic [2:0] pend_off;
  logic [31:0] rd;

  ahb_gpio_slave #(.GPIO_W(GW), .READ_WAIT(RW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY_IN(HREADY_IN),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .HSPLITx(HSPLITx),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );
  // single-slave system: the response mux just forwards this slave's ready
  assign HREADY_IN = HREADYOUT;

  initial forever #5 HCLK = ~HCLK;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(logic [2:0] off);
    case (off)
      3'd0: return m_dout;
      3'd1: return m_dir;
      3'd2: return s1;
      3'd3: return m_en;
      3'd4: return m_stat;
      default: return 32'd0;
    endcase
  endfunction

  // advance one clock, updating the model with what happens at that edge
  task automatic step();
    logic [31:0] clr, rise;
    logic irq_n;
    if (HRESET) begin
      {m_dout, m_dir, m_en, m_stat, s0, s1, s2} = '0;
      m_irq = 1'b0;
    end else begin
      rise = s1 & ~s2;
      irq_n = |(m_stat & m_en);
      clr = '0;
      if (pend_we)
        case (pend_off)
          3'd0: m_dout = HWDATA & MASK;
          3'd1: m_dir = HWDATA & MASK;
          3'd3: m_en = HWDATA & MASK;
          3'd4: clr = HWDATA & MASK;
          default: ;
        endcase
      m_stat = (m_stat & ~clr) | rise;
      m_irq = irq_n;
      s2 = s1;
      s1 = s0;
      s0 = 32'(gpio_in);
    end
    @(posedge HCLK);
    #1;
    check("gpio_out", 32'(gpio_out), m_dout);
    check("gpio_oe", 32'(gpio_oe), m_dir);
    check("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic rd_phase(logic [2:0] off, output logic [31:0] rdata);
    for (int i = 0; i < RW; i++) begin
      check("rd_wait_rdy", 32'(HREADYOUT), 0);
      check("rd_wait_resp", 32'(HRESP), 0);
      check("rd_wait_data", HRDATA, 0);
      step();
    end
    check("rd_rdy", 32'(HREADYOUT), 1);
    check("rd_resp", 32'(HRESP), 0);
    check("rd_data", HRDATA, m_read(off));
    rdata = HRDATA;
    step();
  endtask

  task automatic xfer(logic [31:0] addr, logic wr, logic [2:0] size, logic [31:0] wdata,
                      output logic [31:0] rdata);
    logic [2:0] off;
    logic err;
    off = addr[4:2];
    err = off > 3'd4 || addr[1:0] != 2'b00 || size != 3'b010 || (wr && off == 3'd2);
    HSEL = 1'b1; HADDR = addr; HTRANS = 2'b10; HWRITE = wr; HSIZE = size; HWDATA = $urandom;
    step();
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata; rdata = '0;
    if (err) begin
      check("err1_rdy", 32'(HREADYOUT), 0);
      check("err1_resp", 32'(HRESP), 1);
      step();
      check("err2_rdy", 32'(HREADYOUT), 1);
      check("err2_resp", 32'(HRESP), 1);
      step();
    end else if (wr) begin
      check("wr_rdy", 32'(HREADYOUT), 1);
      check("wr_resp", 32'(HRESP), 0);
      pend_we = 1'b1; pend_off = off;
      step();
      pend_we = 1'b0;
    end else rd_phase(off, rdata);
  endtask

  task automatic pipe_wr_rd(logic [2:0] off, logic [31:0] wdata, output logic [31:0] rdata);
    HSEL = 1'b1; HADDR = {27'd0, off, 2'b00}; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'b010;
    step();
    check("pw_rdy", 32'(HREADYOUT), 1);
    check("pw_resp", 32'(HRESP), 0);
    HWDATA = wdata; pend_we = 1'b1; pend_off = off; HWRITE = 1'b0;
    step();
    pend_we = 1'b0; HSEL = 1'b0; HTRANS = 2'b00;
    rd_phase(off, rdata);
  endtask

  initial begin
    logic [31:0] addr, r;
    logic [2:0] off, size;
    pend_we = 1'b0; pend_off = '0;
    {m_dout, m_dir, m_en, m_stat, s0, s1, s2} = '0;
    m_irq = 1'b0;
    step(); step();
    HRESET = 1'b0;
    check("rst_rdy", 32'(HREADYOUT), 1);
    check("rst_resp", 32'(HRESP), 0);
    check("rst_rdata", HRDATA, 0);
    check("rst_split", 32'(HSPLITx), 0);
    check("rst_irq", 32'(irq), 0);
    // test 1: DIR write then read back
    xfer(32'h4, 1'b1, 3'b010, 32'hA5, rd);
    check("t1_oe", 32'(gpio_oe), 32'hA5);
    xfer(32'h4, 1'b0, 3'b010, 32'h0, rd);
    check("t1_rd", rd, 32'hA5);
    // selected IDLE and BUSY are zero-wait OKAY
    HSEL = 1'b1; HTRANS = 2'b00; step();
    check("idle_rdy", 32'(HREADYOUT), 1);
    check("idle_resp", 32'(HRESP), 0);
    HTRANS = 2'b01; step();
    check("busy_rdy", 32'(HREADYOUT), 1);
    check("busy_resp", 32'(HRESP), 0);
    HSEL = 1'b0; HTRANS = 2'b00;
    // tests 2 and 3: error responses leave registers alone
    xfer(32'h14, 1'b0, 3'b010, 32'h0, rd);
    check("t2_oe", 32'(gpio_oe), 32'hA5);
    xfer(32'h8, 1'b1, 3'b010, 32'h1, rd);
    xfer(32'h0, 1'b1, 3'b001, 32'h55, rd);
    check("t3_out", 32'(gpio_out), 0);
    // test 4: rising edge on pin 3 raises irq
    xfer(32'hC, 1'b1, 3'b010, 32'h8, rd);
    gpio_in = GW'(32'h8);
    step(); step(); step();
    check("t4_irq_early", 32'(irq), 0);
    step();
    check("t4_irq", 32'(irq), 1);
    xfer(32'h10, 1'b0, 3'b010, 32'h0, rd);
    check("t4_stat", rd, 32'h8);
    xfer(32'h10, 1'b1, 3'b010, 32'h8, rd);
    step();
    check("t4_irq_clr", 32'(irq), 0);
    xfer(32'h10, 1'b0, 3'b010, 32'h0, rd);
    check("t4_stat_clr", rd, 32'h0);
    // test 5: edge coincides with w1c of the same bit
    gpio_in = '0;
    repeat (4) step();
    xfer(32'h10, 1'b1, 3'b010, MASK, rd);
    gpio_in = GW'(32'h1);
    step();
    xfer(32'h10, 1'b1, 3'b010, 32'h1, rd);
    xfer(32'h10, 1'b0, 3'b010, 32'h0, rd);
    check("t5_set_wins", rd & 32'h1, 32'h1);
    // randomized traffic
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 3) == 0) gpio_in = GW'($urandom);
      repeat ($urandom_range(0, 2)) step();
      off = $urandom_range(0, 7) < 6 ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
      r = $urandom;
      addr = {r[31:5], off, 2'b00};
      if ($urandom_range(0, 9) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      size = $urandom_range(0, 9) == 0 ? 3'($urandom_range(0, 7)) : 3'b010;
      if ($urandom_range(0, 7) == 0 && off <= 3'd4 && off != 3'd2) pipe_wr_rd(off, $urandom, rd);
      else xfer(addr, 1'($urandom_range(0, 1)), size, $urandom, rd);
    end
    // test 6: pipelined write then read, then reset inside the read wait
    pipe_wr_rd(3'd0, 32'h3C, rd);
    check("t6_pipe", rd, 32'h3C);
    HSEL = 1'b1; HADDR = 32'h0; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'b010;
    step();
    HSEL = 1'b0; HTRANS = 2'b00;
    check("t6_in_wait", 32'(HREADYOUT), 0);
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    check("t6_rst_rdy", 32'(HREADYOUT), 1);
    check("t6_rst_resp", 32'(HRESP), 0);
    check("t6_rst_out", 32'(gpio_out), 0);
    check("t6_rst_rdata", HRDATA, 0);
    step();
    check("t6_post_rdy", 32'(HREADYOUT), 1);
    check("split", 32'(HSPLITx), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
